// File: rtl/avr_bus_master_if.sv
// Parallel a_* strobe/address lines between the SPI bridge (master) and the FDC CPLD (slave).
interface avr_bus_master_if;
  logic [15:0] a_addrbus;
  logic        a_rw;
  logic        a_sel;

  modport master (output a_addrbus, output a_rw, output a_sel);
  modport slave  (input  a_addrbus, input  a_rw, input  a_sel);
endinterface

// File: rtl/avr_bus_master.sv
// SPI-slave to a_* bus-master bridge: one 4-byte SPI frame becomes one a_sel read/write cycle.
// Optional macro AVR_BUS_MASTER_IRQ_EN enables the intr synchronizer, host_irq_n and STATUS pending bits.
module avr_bus_master #(
  parameter int SETUP_CYCLES = 2,
  parameter int SEL_CYCLES   = 12,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic                    clock_50,
  input  logic                    reset_n,
  input  logic                    spi_sck,
  input  logic                    spi_ss_n,
  input  logic                    spi_mosi,
  output wire                     spi_miso,
  avr_bus_master_if.master        bus,
  inout  wire  [7:0]              a_databus,
  input  logic [1:0]              intr,
  output logic                    host_irq_n
);
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SEL, S_HOLD} state_t;

  logic [2:0]       sck_p, ss_p;
  logic [1:0]       mosi_p;
  logic             sck_rise, sck_fall, ss_fall, sel_act;
  logic [2:0]       bit_cnt, byte_cnt;
  logic [6:0]       rx_sr;
  logic [7:0]       rx_byte, tx_sr, addr_hi, addr_lo;
  logic             cmd_rd, byte_done, launch, ovr_clr;
  logic [15:0]      launch_addr;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      addr_q;
  logic             rw_q, sel_q, overrun;
  logic [7:0]       wdata, rdata, status;
  logic [1:0]       pending;

  // SPI pin synchronizers; the third stage is only for edge detection
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      sck_p  <= '0;
      ss_p   <= '1;
      mosi_p <= '0;
    end else begin
      sck_p  <= {sck_p[1:0], spi_sck};
      ss_p   <= {ss_p[1:0], spi_ss_n};
      mosi_p <= {mosi_p[0], spi_mosi};
    end
  end

  assign sck_rise  = sck_p[1] & ~sck_p[2];
  assign sck_fall  = ~sck_p[1] & sck_p[2];
  assign ss_fall   = ~ss_p[1] & ss_p[2];
  assign sel_act   = ~ss_p[1];
  assign rx_byte   = {rx_sr, mosi_p[1]};
  // byte_cnt saturates at 4 so trailing bytes neither launch nor overwrite fields
  assign byte_done = sel_act & sck_rise & (bit_cnt == 3'd7) & (byte_cnt < 3'd4);
  assign launch    = byte_done & ((byte_cnt == 3'd2 & cmd_rd) | (byte_cnt == 3'd3 & ~cmd_rd));
  assign ovr_clr   = byte_done & (byte_cnt == 3'd0);
  assign launch_addr = {addr_hi, (byte_cnt == 3'd2) ? rx_byte : addr_lo};
  assign status    = {state != S_IDLE, overrun, 4'b0000, pending};

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      rx_sr    <= '0;
      cmd_rd   <= 1'b0;
      addr_hi  <= '0;
      addr_lo  <= '0;
      tx_sr    <= '0;
    end else if (ss_fall) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx_sr    <= status;
    end else if (sel_act) begin
      if (sck_rise) begin
        rx_sr   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          case (byte_cnt)
            3'd0:    cmd_rd  <= rx_byte[7];
            3'd1:    addr_hi <= rx_byte;
            3'd2:    addr_lo <= rx_byte;
            default: ;
          endcase
          byte_cnt <= byte_cnt + 3'd1;
        end
      end else if (sck_fall) begin
        // bit_cnt back at 0 means the previous byte just finished: load the next one
        if (bit_cnt == 3'd0) tx_sr <= (byte_cnt == 3'd1) ? rdata : 8'h00;
        else                 tx_sr <= {tx_sr[6:0], 1'b0};
      end
    end
  end

  assign spi_miso = spi_ss_n ? 1'bz : tx_sr[7];

  // Bus cycle FSM; launches arriving while busy are dropped and flagged
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      sel_q   <= 1'b1;
      wdata   <= '0;
      rdata   <= '0;
      overrun <= 1'b0;
    end else begin
      if (launch && state != S_IDLE) overrun <= 1'b1;
      else if (ovr_clr)              overrun <= 1'b0;
      case (state)
        S_IDLE: if (launch) begin
          state  <= S_SETUP;
          cnt    <= CNT_W'(SETUP_CYCLES - 1);
          addr_q <= launch_addr;
          rw_q   <= cmd_rd;
          wdata  <= rx_byte;
        end
        S_SETUP: if (cnt == '0) begin
          state <= S_SEL;
          cnt   <= CNT_W'(SEL_CYCLES - 1);
          sel_q <= 1'b0;
        end else cnt <= cnt - 1'b1;
        S_SEL: if (cnt == '0) begin
          state <= S_HOLD;
          cnt   <= CNT_W'(HOLD_CYCLES - 1);
          sel_q <= 1'b1;
          if (rw_q) rdata <= a_databus;
        end else cnt <= cnt - 1'b1;
        default: if (cnt == '0) begin
          state <= S_IDLE;
          rw_q  <= 1'b1;
        end else cnt <= cnt - 1'b1;
      endcase
    end
  end

  assign bus.a_addrbus = addr_q;
  assign bus.a_rw      = rw_q;
  assign bus.a_sel     = sel_q;
  assign a_databus     = (state != S_IDLE && !rw_q) ? wdata : 8'bz;

`ifdef AVR_BUS_MASTER_IRQ_EN
  logic [1:0] intr_p0, intr_p1;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      intr_p0 <= 2'b11;
      intr_p1 <= 2'b11;
    end else begin
      intr_p0 <= intr;
      intr_p1 <= intr_p0;
    end
  end

  assign pending    = ~intr_p1;
  assign host_irq_n = &intr_p1;
`else
  logic [1:0] intr_unused;
  assign intr_unused = intr;
  assign pending     = 2'b00;
  assign host_irq_n  = 1'b1;
`endif
endmodule
